// File: rtl/music_pkg.sv
// Shared definitions for the music-game controllers: FSM states, field widths,
// end-marker value and the {pitch, length} slice positions of a song ROM word.
package music_pkg;

    localparam int unsigned PITCH_W_DEF    = 4;
    localparam int unsigned LEN_W_DEF      = 4;
    localparam int unsigned END_MARKER_LEN = 0;
    localparam int unsigned LEN_LSB        = 0;

    // Pitch sits directly above the length field.
    function automatic int unsigned pitch_lsb(input int unsigned len_w);
        return len_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/note_len_counter.sv
// Counts accepted beat ticks within one note and flags its first and last tick.
module note_len_counter
    import music_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick_en,
    input  logic [LEN_W-1:0] length,
    output logic             first_tick,
    output logic             last_tick
);

    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0] len_last;

    assign len_last   = length - 1'b1;
    assign first_tick = (len_cnt_q == '0);
    assign last_tick  = (len_cnt_q == len_last);

    always_comb begin
        len_cnt_d = len_cnt_q;
        if (clear) begin
            len_cnt_d = '0;
        end else if (tick_en) begin
            len_cnt_d = len_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_cnt_q <= '0;
        end else begin
            len_cnt_q <= len_cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song-table player: fetches {pitch, length} entries and holds each pitch for its
// length in beat ticks. Define NOTE_SEQ_LOOP_EN to loop the song instead of stopping.
module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SONG_LEN = 32,
    parameter int unsigned LEN_W    = LEN_W_DEF,
    parameter int unsigned PITCH_W  = PITCH_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     pause,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [PITCH_W+LEN_W-1:0] rom_data,
    output logic [PITCH_W-1:0]       pitch,
    output logic                     note_on,
    output logic                     led2shift,
    output logic                     change,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PITCH_LSB = pitch_lsb(LEN_W);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic [LEN_W-1:0]   length_q, length_d;

    logic [LEN_W-1:0]   rom_len;
    logic [PITCH_W-1:0] rom_pitch;
    logic               beat, first_tick, last_tick, last_addr;

    assign rom_len   = rom_data[LEN_LSB +: LEN_W];
    assign rom_pitch = rom_data[PITCH_LSB +: PITCH_W];
    assign beat      = (state_q == ST_PLAY) && tick && !pause;
    assign last_addr = (addr_q == ADDR_W'(SONG_LEN - 1));

    note_len_counter #(.LEN_W(LEN_W)) u_len_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == ST_LOAD),
        .tick_en    (beat),
        .length     (length_q),
        .first_tick (first_tick),
        .last_tick  (last_tick)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pitch_d   = pitch_q;
        length_d  = length_q;
        led2shift = 1'b0;
        change    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (rom_len == LEN_W'(END_MARKER_LEN)) begin
`ifdef NOTE_SEQ_LOOP_EN
                    // A marker at entry 0 means nothing playable: stop rather than spin.
                    if (addr_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    pitch_d  = rom_pitch;
                    length_d = rom_len;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (beat) begin
                    led2shift = first_tick;
                    if (last_tick) begin
                        change = 1'b1;
                        if (last_addr) begin
`ifdef NOTE_SEQ_LOOP_EN
                            state_d = ST_FETCH;
                            addr_d  = '0;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = addr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            pitch_q  <= '0;
            length_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pitch_q  <= pitch_d;
            length_q <= length_d;
        end
    end

    assign rom_addr = addr_q;
    assign pitch    = pitch_q;
    assign note_on  = (state_q == ST_PLAY);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random songs checked against a
// note-level model of the song (current note index and ticks played in it).
module tb_note_sequencer;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned SONG_LEN = 4;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned PITCH_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst, tick, start, pause;
    logic [ADDR_W-1:0]        rom_addr;
    logic [PITCH_W+LEN_W-1:0] rom_data;
    logic [PITCH_W-1:0]       pitch;
    logic                     note_on, led2shift, change, busy, done;

    logic [7:0] rom [32];

    int checks   = 0;
    int failures = 0;

    // Note-level model of the song being played.
    int n, k;
    bit playing, finished;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    note_sequencer #(
        .ADDR_W   (ADDR_W),
        .SONG_LEN (SONG_LEN),
        .LEN_W    (LEN_W),
        .PITCH_W  (PITCH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .pause     (pause),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pitch     (pitch),
        .note_on   (note_on),
        .led2shift (led2shift),
        .change    (change),
        .busy      (busy),
        .done      (done)
    );

    function automatic int len_of(input int i);
        logic [7:0] e;
        e = rom[i];
        return int'(e[3:0]);
    endfunction

    function automatic int pitch_of(input int i);
        logic [7:0] e;
        e = rom[i];
        return int'(e[7:4]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".note_on"}, 8'(note_on), 8'(playing));
        check({tag, ".busy"},    8'(busy),    8'(playing));
        check({tag, ".done"},    8'(done),    8'(finished));
        if (playing) begin
            check({tag, ".pitch"},    8'(pitch),    8'(pitch_of(n)));
            check({tag, ".rom_addr"}, 8'(rom_addr), 8'(n));
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'hF1;
    endtask

    // Advance the model past a completed note.
    task automatic next_note();
        k = 0;
        if (n == SONG_LEN - 1 || len_of(n + 1) == 0) begin
`ifdef NOTE_SEQ_LOOP_EN
            n = 0;
            if (len_of(0) == 0) begin
                playing  = 1'b0;
                finished = 1'b1;
            end
`else
            playing  = 1'b0;
            finished = 1'b1;
`endif
        end else begin
            n++;
        end
    endtask

    task automatic do_reset(input logic with_start);
        @(posedge clk); #1;
        rst = 1'b1; start = with_start; tick = 1'b0; pause = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        playing = 1'b0; finished = 1'b0; n = 0; k = 0;
        @(negedge clk);
        check("rst.pitch",     8'(pitch),     8'h00);
        check("rst.note_on",   8'(note_on),   8'h00);
        check("rst.led2shift", 8'(led2shift), 8'h00);
        check("rst.change",    8'(change),    8'h00);
        check("rst.busy",      8'(busy),      8'h00);
        check("rst.done",      8'(done),      8'h00);
        check("rst.rom_addr",  8'(rom_addr),  8'h00);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start.fetch.note_on", 8'(note_on), 8'h00);
        check("start.fetch.busy",    8'(busy),    8'h01);
        @(negedge clk);
        check("start.load.note_on",  8'(note_on), 8'h00);
        n = 0; k = 0;
        playing  = (len_of(0) != 0);
        finished = !playing;
        @(negedge clk);
        check_state("start");
    endtask

    task automatic start_while_busy();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("busy_start");
    endtask

    // One tick (optionally paused); a second tick lands in the LOAD cycle if asked.
    task automatic step_tick(input bit p, input bit load_tick);
        bit acc, el, ec;
        @(posedge clk); #1;
        tick = 1'b1; pause = p;
        @(negedge clk);
        acc = playing && !p;
        el  = acc && (k == 0);
        ec  = acc && (k + 1 == len_of(n));
        check("tick.led2shift", 8'(led2shift), 8'(el));
        check("tick.change",    8'(change),    8'(ec));
        check("tick.note_on",   8'(note_on),   8'(playing));
        if (acc) begin
            k++;
            if (k == len_of(n)) next_note();
        end
        @(posedge clk); #1 tick = 1'b0;
        if (load_tick) begin
            @(posedge clk); #1 tick = 1'b1;
            @(negedge clk);
            check("load_tick.led2shift", 8'(led2shift), 8'h00);
            check("load_tick.change",    8'(change),    8'h00);
            check("load_tick.note_on",   8'(note_on),   8'h00);
            @(posedge clk); #1 tick = 1'b0;
            repeat (4) @(posedge clk);
        end else begin
            repeat (6) @(posedge clk);
        end
        @(negedge clk);
        check_state("after_tick");
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        n = 0; k = 0; playing = 1'b0; finished = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init.note_on",  8'(note_on),  8'h00);
        check("init.busy",     8'(busy),     8'h00);
        check("init.done",     8'(done),     8'h00);
        check("init.pitch",    8'(pitch),    8'h00);
        check("init.rom_addr", 8'(rom_addr), 8'h00);

        // Basic play: {3,2},{5,1},end.
        clear_rom();
        rom[0] = 8'h32; rom[1] = 8'h51; rom[2] = 8'h00;
        do_reset(1'b0);
        do_start();
        for (int i = 0; i < 3; i++) step_tick(1'b0, 1'b0);
`ifndef NOTE_SEQ_LOOP_EN
        check("basic.done", 8'(done), 8'h01);
`endif

        // Pause held across three ticks of a length-4 note.
        clear_rom();
        rom[0] = 8'h74; rom[1] = 8'h00;
        do_reset(1'b0);
        do_start();
        step_tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_tick(1'b0, 1'b0);

        // Tick in the LOAD cycle after a change is dropped.
        clear_rom();
        rom[0] = 8'h21; rom[1] = 8'h93; rom[2] = 8'h00;
        do_reset(1'b0);
        do_start();
        step_tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_tick(1'b0, 1'b0);

        // Start while busy, then reset mid-note together with start.
        clear_rom();
        rom[0] = 8'h43; rom[1] = 8'h62; rom[2] = 8'h00;
        do_reset(1'b0);
        do_start();
        step_tick(1'b0, 1'b0);
        start_while_busy();
        step_tick(1'b0, 1'b0);
        do_reset(1'b1);
        @(negedge clk);
        check("rst_start.busy", 8'(busy), 8'h00);
        do_start();
        check("restart.pitch", 8'(pitch), 8'h04);
        for (int i = 0; i < 5; i++) step_tick(1'b0, 1'b0);

        // End of table without a marker; entry 4 would be an overrun.
        clear_rom();
        rom[0] = 8'h12; rom[1] = 8'h21; rom[2] = 8'h31; rom[3] = 8'h42;
        do_reset(1'b0);
        do_start();
        for (int i = 0; i < 6; i++) step_tick(1'b0, 1'b0);
`ifdef NOTE_SEQ_LOOP_EN
        check("eot.pitch", 8'(pitch), 8'h01);
        check("eot.done",  8'(done),  8'h00);
`else
        check("eot.done",  8'(done),  8'h01);
`endif

        // Entry 0 is the end marker: stops immediately in either build.
        clear_rom();
        rom[0] = 8'hA0;
        do_reset(1'b0);
        do_start();
        check("empty.done", 8'(done), 8'h01);

        // Random songs with random pauses.
        for (int s = 0; s < 6; s++) begin
            clear_rom();
            for (int i = 0; i < int'(SONG_LEN); i++) begin
                rom[i][7:4] = 4'($urandom_range(0, 15));
                rom[i][3:0] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
            end
            do_reset(1'b0);
            do_start();
            for (int t = 0; t < 60 && !finished; t++) begin
                step_tick($urandom_range(0, 3) == 0, 1'b0);
            end
            check("rand.done", 8'(done), 8'(finished));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
